// File: rtl/pc_sequencer_if.sv
// Command and status bundle of the program-counter sequencer.
// Commands are level inputs sampled on every rising clock edge; there is no backpressure.
interface pc_sequencer_if #(
  parameter int PC_W  = 13,
  parameter int JA_W  = 11,
  parameter int DEPTH = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             incr_en;
  logic             skip_en;
  logic             j_en;
  logic             j_push_en;
  logic             pop_en;
  logic             isr_en;
  logic [JA_W-1:0]  j_addr;
  logic             pclath_wr_en;
  logic [PC_W-9:0]  pclath_in;
  logic             pcl_wr_en;
  logic [7:0]       pcl_in;
  logic             err_clr;
  logic [PC_W-1:0]  pc_out;
  logic [PC_W-9:0]  pclath_out;
  logic [7:0]       pcl_out;
  logic [LVL_W-1:0] stk_level;
  logic             stk_empty;
  logic             stk_full;
  logic             stk_ovf;
  logic             stk_unf;

  modport master (
    output incr_en, skip_en, j_en, j_push_en, pop_en, isr_en, j_addr,
           pclath_wr_en, pclath_in, pcl_wr_en, pcl_in, err_clr,
    input  pc_out, pclath_out, pcl_out, stk_level, stk_empty, stk_full,
           stk_ovf, stk_unf
  );

  modport slave (
    input  incr_en, skip_en, j_en, j_push_en, pop_en, isr_en, j_addr,
           pclath_wr_en, pclath_in, pcl_wr_en, pcl_in, err_clr,
    output pc_out, pclath_out, pcl_out, stk_level, stk_empty, stk_full,
           stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with PCLATH paging, computed jumps, interrupts and a return stack
// that either wraps (overwrites the oldest entry) or saturates.
module pc_sequencer #(
  parameter int              PC_W    = 13,
  parameter int              JA_W    = 11,
  parameter int              DEPTH   = 8,
  parameter logic [PC_W-1:0] ISR_VEC = PC_W'(4),
  parameter logic [PC_W-1:0] RST_VEC = PC_W'(0),
  parameter bit              WRAP    = 1'b1
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  localparam int SP_W  = $clog2(DEPTH);
  localparam int LVL_W = SP_W + 1;
  // Bits of the jump target that come from PCLATH rather than j_addr.
  localparam logic [PC_W-1:0] HI_MASK = ~PC_W'((32'd1 << JA_W) - 32'd1);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-9:0]  pclath_q, pclath_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, stk_we, full;
  logic [PC_W-1:0]  target, stk_top;
  logic [PC_W-1:0]  stk_mem [DEPTH];

  assign full    = (lvl_q == LVL_W'(DEPTH));
  assign target  = ({pclath_q, 8'h00} & HI_MASK) | PC_W'(bus.j_addr);
  assign stk_top = stk_mem[sp_q - SP_W'(1)];

  always_comb begin
    pc_d     = pc_q;
    pclath_d = pclath_q;
    sp_d     = sp_q;
    lvl_d    = lvl_q;
    ovf_d    = ovf_q & ~bus.err_clr;
    unf_d    = unf_q & ~bus.err_clr;
    push     = 1'b0;
    stk_we   = 1'b0;
    if (bus.isr_en) begin
      pc_d = ISR_VEC;
      push = 1'b1;
    end else if (bus.j_en || bus.j_push_en) begin
      pc_d = target;
      push = bus.j_push_en;
    end else if (bus.pop_en) begin
      if (lvl_q != '0) begin
        pc_d  = stk_top;
        sp_d  = sp_q - SP_W'(1);
        lvl_d = lvl_q - LVL_W'(1);
      end else begin
        unf_d = 1'b1;
        if (WRAP) begin
          pc_d = stk_top;
          sp_d = sp_q - SP_W'(1);
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
    end else begin
      // PCL load uses the PCLATH value from before any same-cycle PCLATH write.
      if (bus.pcl_wr_en)    pc_d = {pclath_q, bus.pcl_in};
      else if (bus.skip_en) pc_d = pc_q + PC_W'(2);
      else if (bus.incr_en) pc_d = pc_q + PC_W'(1);
      if (bus.pclath_wr_en) pclath_d = bus.pclath_in;
    end

    if (push) begin
      if (!full) begin
        stk_we = 1'b1;
        sp_d   = sp_q + SP_W'(1);
        lvl_d  = lvl_q + LVL_W'(1);
      end else begin
        ovf_d = 1'b1;
        if (WRAP) begin
          stk_we = 1'b1;
          sp_d   = sp_q + SP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RST_VEC;
      pclath_q <= '0;
      sp_q     <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pclath_q <= pclath_d;
      sp_q     <= sp_d;
      lvl_q    <= lvl_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Entries are never reset; reset only forgets them through the pointer and level.
  always_ff @(posedge clk) begin
    if (stk_we && !rst) stk_mem[sp_q] <= pc_q;
  end

  assign bus.pc_out     = bus.pcl_wr_en ? {pclath_q, bus.pcl_in} : pc_q;
  assign bus.pclath_out = pc_q[PC_W-1:8];
  assign bus.pcl_out    = pc_q[7:0];
  assign bus.stk_level  = lvl_q;
  assign bus.stk_empty  = (lvl_q == '0);
  assign bus.stk_full   = full;
  assign bus.stk_ovf    = ovf_q;
  assign bus.stk_unf    = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a wrapping and a saturating instance share one stimulus stream.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        incr_en, skip_en, j_en, j_push_en, pop_en, isr_en;
  logic        pclath_wr_en, pcl_wr_en, err_clr;
  logic [10:0] j_addr;
  logic [4:0]  pclath_in;
  logic [7:0]  pcl_in;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(13), .JA_W(11), .DEPTH(8)) if_w ();
  pc_sequencer_if #(.PC_W(13), .JA_W(11), .DEPTH(8)) if_s ();

  assign if_w.incr_en = incr_en;           assign if_s.incr_en = incr_en;
  assign if_w.skip_en = skip_en;           assign if_s.skip_en = skip_en;
  assign if_w.j_en = j_en;                 assign if_s.j_en = j_en;
  assign if_w.j_push_en = j_push_en;       assign if_s.j_push_en = j_push_en;
  assign if_w.pop_en = pop_en;             assign if_s.pop_en = pop_en;
  assign if_w.isr_en = isr_en;             assign if_s.isr_en = isr_en;
  assign if_w.j_addr = j_addr;             assign if_s.j_addr = j_addr;
  assign if_w.pclath_wr_en = pclath_wr_en; assign if_s.pclath_wr_en = pclath_wr_en;
  assign if_w.pclath_in = pclath_in;       assign if_s.pclath_in = pclath_in;
  assign if_w.pcl_wr_en = pcl_wr_en;       assign if_s.pcl_wr_en = pcl_wr_en;
  assign if_w.pcl_in = pcl_in;             assign if_s.pcl_in = pcl_in;
  assign if_w.err_clr = err_clr;           assign if_s.err_clr = err_clr;

  pc_sequencer #(.PC_W(13), .JA_W(11), .DEPTH(8), .ISR_VEC(13'h004), .RST_VEC(13'h000),
                 .WRAP(1'b1)) u_wrap (.clk(clk), .rst(rst), .bus(if_w));
  pc_sequencer #(.PC_W(13), .JA_W(11), .DEPTH(8), .ISR_VEC(13'h004), .RST_VEC(13'h000),
                 .WRAP(1'b0)) u_sat (.clk(clk), .rst(rst), .bus(if_s));

  // Index 0 = wrapping instance, 1 = saturating instance.
  logic [12:0] pc_o [2];
  logic [3:0]  lvl_o [2];
  logic        emp_o [2], full_o [2], ovf_o [2], unf_o [2];
  assign pc_o[0] = if_w.pc_out;     assign pc_o[1] = if_s.pc_out;
  assign lvl_o[0] = if_w.stk_level; assign lvl_o[1] = if_s.stk_level;
  assign emp_o[0] = if_w.stk_empty; assign emp_o[1] = if_s.stk_empty;
  assign full_o[0] = if_w.stk_full; assign full_o[1] = if_s.stk_full;
  assign ovf_o[0] = if_w.stk_ovf;   assign ovf_o[1] = if_s.stk_ovf;
  assign unf_o[0] = if_w.stk_unf;   assign unf_o[1] = if_s.stk_unf;

  // Reference model: wrapping stack as a ring of 8 slots, saturating stack as a queue.
  int          m_pc [2];
  int          m_pclath [2];
  bit          m_ovf [2], m_unf [2];
  logic [12:0] ring [8];
  int          ring_ptr, ring_lvl;
  logic [12:0] sq [$];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int  nxt;
      bit  do_push;
      if (rst) begin
        m_pc[k] = 0; m_pclath[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        if (k == 0) begin ring_ptr = 0; ring_lvl = 0; end
        else sq.delete();
        continue;
      end
      nxt = m_pc[k];
      do_push = 0;
      if (err_clr) begin m_ovf[k] = 0; m_unf[k] = 0; end
      if (isr_en) begin
        nxt = 4; do_push = 1;
      end else if (j_en || j_push_en) begin
        nxt = ((m_pclath[k] * 256) & 'h1800) | int'(j_addr);
        do_push = j_push_en;
      end else if (pop_en) begin
        if (k == 0) begin
          ring_ptr = (ring_ptr + 7) % 8;
          nxt = int'(ring[ring_ptr]);
          if (ring_lvl > 0) ring_lvl--;
          else m_unf[k] = 1;
        end else if (sq.size() > 0) begin
          nxt = int'(sq.pop_back());
        end else begin
          nxt = m_pc[k] + 1; m_unf[k] = 1;
        end
      end else begin
        if (pcl_wr_en) nxt = m_pclath[k] * 256 + int'(pcl_in);
        else if (skip_en) nxt = m_pc[k] + 2;
        else if (incr_en) nxt = m_pc[k] + 1;
        if (pclath_wr_en) m_pclath[k] = int'(pclath_in);
      end
      if (do_push) begin
        if (k == 0) begin
          ring[ring_ptr] = 13'(m_pc[k]);
          ring_ptr = (ring_ptr + 1) % 8;
          if (ring_lvl < 8) ring_lvl++;
          else m_ovf[k] = 1;
        end else if (sq.size() < 8) sq.push_back(13'(m_pc[k]));
        else m_ovf[k] = 1;
      end
      m_pc[k] = nxt % 8192;
    end
  endtask

  function automatic logic [33:0] exp_vec(int k);
    int pco, lvl;
    pco = pcl_wr_en ? (m_pclath[k] * 256 + int'(pcl_in)) : m_pc[k];
    lvl = (k == 0) ? ring_lvl : sq.size();
    return {13'(pco), 5'(m_pc[k] / 256), 8'(m_pc[k] % 256), 4'(lvl),
            lvl == 0, lvl == 8, m_ovf[k], m_unf[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic idle();
    {incr_en, skip_en, j_en, j_push_en, pop_en, isr_en} = '0;
    {pclath_wr_en, pcl_wr_en, err_clr, rst} = '0;
    j_addr = '0; pclath_in = '0; pcl_in = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; incr_en = 1'b1; pop_en = 1'b1;
    tick(); tick();
    idle(); #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (pc_o[k] !== 13'h000 || lvl_o[k] !== 4'd0 || emp_o[k] !== 1'b1 || full_o[k] !== 1'b0
          || ovf_o[k] !== 1'b0 || unf_o[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset[%0d]: pc=%h lvl=%0d e=%b f=%b o=%b u=%b, want pc=0 lvl=0 e=1 f=0 o=0 u=0",
                 k, pc_o[k], lvl_o[k], emp_o[k], full_o[k], ovf_o[k], unf_o[k]);
      end
    end
  endtask

  task automatic test_incr_skip();
    do_reset();
    incr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (pc_o[0] !== 13'(i)) begin
        bad++; $display("FAIL incr step %0d: pc=%h want %h", i, pc_o[0], 13'(i));
      end
      if (i < 3) tick();
    end
    skip_en = 1'b1;
    tick(); idle(); #1;
    total++;
    if (pc_o[1] !== 13'h005) begin bad++; $display("FAIL skip: pc=%h want 005", pc_o[1]); end
  endtask

  task automatic test_wrap_arith();
    do_reset();
    pclath_wr_en = 1'b1; pclath_in = 5'h1f; tick(); idle();
    pcl_wr_en = 1'b1; pcl_in = 8'hff; tick(); idle();
    incr_en = 1'b1; tick(); idle(); #1;
    total++;
    if (pc_o[0] !== 13'h000) begin bad++; $display("FAIL incr wrap: pc=%h want 000", pc_o[0]); end
    pcl_wr_en = 1'b1; pcl_in = 8'hff; tick(); idle();
    skip_en = 1'b1; tick(); idle(); #1;
    total++;
    if (pc_o[1] !== 13'h001) begin bad++; $display("FAIL skip wrap: pc=%h want 001", pc_o[1]); end
  endtask

  task automatic test_jump_call();
    do_reset();
    pclath_wr_en = 1'b1; pclath_in = 5'h18; pcl_wr_en = 1'b1; pcl_in = 8'h10;
    tick(); idle(); #1;
    total++;
    if (pc_o[0] !== 13'h010) begin bad++; $display("FAIL pcl with pclath: pc=%h want 010", pc_o[0]); end
    j_push_en = 1'b1; j_addr = 11'h123; tick(); idle(); #1;
    total++;
    if (pc_o[0] !== 13'h1923 || lvl_o[0] !== 4'd1) begin
      bad++; $display("FAIL call: pc=%h lvl=%0d want 1923 lvl=1", pc_o[0], lvl_o[0]);
    end
    pop_en = 1'b1; tick(); idle(); #1;
    total++;
    if (pc_o[1] !== 13'h010 || lvl_o[1] !== 4'd0 || emp_o[1] !== 1'b1) begin
      bad++; $display("FAIL return: pc=%h lvl=%0d e=%b want 010 lvl=0 e=1", pc_o[1], lvl_o[1], emp_o[1]);
    end
  endtask

  task automatic test_overflow();
    logic [12:0] exp_pc [2];
    do_reset();
    incr_en = 1'b1; tick(); idle();
    for (int c = 1; c <= 9; c++) begin
      j_push_en = 1'b1; j_addr = 11'(12'h100 + 16 * c); tick();
    end
    idle(); #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ovf_o[k] !== 1'b1 || lvl_o[k] !== 4'd8 || full_o[k] !== 1'b1) begin
        bad++; $display("FAIL overflow[%0d]: o=%b lvl=%0d f=%b want o=1 lvl=8 f=1",
                        k, ovf_o[k], lvl_o[k], full_o[k]);
      end
    end
    for (int p = 0; p < 8; p++) begin
      pop_en = 1'b1; tick(); idle(); #1;
      exp_pc[0] = 13'(12'h100 + 16 * (8 - p));
      exp_pc[1] = (p < 7) ? 13'(12'h100 + 16 * (7 - p)) : 13'h001;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (pc_o[k] !== exp_pc[k]) begin
          bad++; $display("FAIL pop %0d[%0d]: pc=%h want %h", p, k, pc_o[k], exp_pc[k]);
        end
      end
    end
    pop_en = 1'b1; tick(); idle(); #1;
    exp_pc[0] = 13'h180; exp_pc[1] = 13'h002;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (pc_o[k] !== exp_pc[k] || unf_o[k] !== 1'b1 || lvl_o[k] !== 4'd0) begin
        bad++; $display("FAIL underflow[%0d]: pc=%h u=%b lvl=%0d want %h u=1 lvl=0",
                        k, pc_o[k], unf_o[k], lvl_o[k], exp_pc[k]);
      end
    end
    err_clr = 1'b1; tick(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ovf_o[k] !== 1'b0 || unf_o[k] !== 1'b0) begin
        bad++; $display("FAIL err_clr[%0d]: o=%b u=%b want 0 0", k, ovf_o[k], unf_o[k]);
      end
    end
    err_clr = 1'b1; pop_en = 1'b1; tick(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (unf_o[k] !== 1'b1) begin
        bad++; $display("FAIL clr vs new unf[%0d]: u=%b want 1", k, unf_o[k]);
      end
    end
  endtask

  task automatic test_isr();
    do_reset();
    pcl_wr_en = 1'b1; pcl_in = 8'h55; tick(); idle();
    isr_en = 1'b1; pop_en = 1'b1; j_en = 1'b1; j_addr = 11'h3ff; tick(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (pc_o[k] !== 13'h004 || lvl_o[k] !== 4'd1) begin
        bad++; $display("FAIL isr priority[%0d]: pc=%h lvl=%0d want 004 lvl=1", k, pc_o[k], lvl_o[k]);
      end
    end
    incr_en = 1'b1; tick(); idle();
    pop_en = 1'b1; tick(); idle(); #1;
    total++;
    if (pc_o[0] !== 13'h055 || lvl_o[0] !== 4'd0) begin
      bad++; $display("FAIL isr return: pc=%h lvl=%0d want 055 lvl=0", pc_o[0], lvl_o[0]);
    end
  endtask

  task automatic test_pcl_reset();
    do_reset();
    pclath_wr_en = 1'b1; pclath_in = 5'h02; tick(); idle();
    pcl_wr_en = 1'b1; pcl_in = 8'h40; incr_en = 1'b1; #1;
    total++;
    if (pc_o[0] !== 13'h240) begin bad++; $display("FAIL pcl forward: pc_out=%h want 240", pc_o[0]); end
    tick(); idle(); #1;
    total++;
    if (pc_o[0] !== 13'h240 || if_w.pclath_out !== 5'h02 || if_w.pcl_out !== 8'h40) begin
      bad++; $display("FAIL pcl load: pc=%h hi=%h lo=%h want 240 02 40",
                      pc_o[0], if_w.pclath_out, if_w.pcl_out);
    end
    pop_en = 1'b1; tick(); idle();
    j_push_en = 1'b1; j_addr = 11'h077; tick(); idle();
    rst = 1'b1; incr_en = 1'b1; tick(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (pc_o[k] !== 13'h000 || unf_o[k] !== 1'b0 || ovf_o[k] !== 1'b0 || lvl_o[k] !== 4'd0) begin
        bad++; $display("FAIL mid reset[%0d]: pc=%h u=%b o=%b lvl=%0d want 0 0 0 0",
                        k, pc_o[k], unf_o[k], ovf_o[k], lvl_o[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [33:0] got, exp;
    for (int n = 0; n < 600; n++) begin
      incr_en      = 1'($urandom_range(0, 1));
      skip_en      = ($urandom_range(0, 3) == 0);
      j_en         = ($urandom_range(0, 7) == 0);
      j_push_en    = ($urandom_range(0, 4) == 0);
      pop_en       = ($urandom_range(0, 3) == 0);
      isr_en       = ($urandom_range(0, 15) == 0);
      j_addr       = 11'($urandom_range(0, 2047));
      pclath_wr_en = ($urandom_range(0, 3) == 0);
      pclath_in    = 5'($urandom_range(0, 31));
      pcl_wr_en    = ($urandom_range(0, 7) == 0);
      pcl_in       = 8'($urandom_range(0, 255));
      err_clr      = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 79) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        got = (k == 0) ? {if_w.pc_out, if_w.pclath_out, if_w.pcl_out, if_w.stk_level,
                          if_w.stk_empty, if_w.stk_full, if_w.stk_ovf, if_w.stk_unf}
                       : {if_s.pc_out, if_s.pclath_out, if_s.pcl_out, if_s.stk_level,
                          if_s.stk_empty, if_s.stk_full, if_s.stk_ovf, if_s.stk_unf};
        exp = exp_vec(k);
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL random cyc %0d[%0d]: {pc,hi,lo,lvl,e,f,o,u} got %h want %h", n, k, got, exp);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_incr_skip();
    test_wrap_arith();
    test_jump_call();
    test_overflow();
    test_isr();
    test_pcl_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 13, program counter width; legal range 9..16.
REQ-002 Parameter JA_W, default 11, jump-address width; legal range 8..PC_W.
REQ-003 Parameter DEPTH, default 8, return-stack entries; power of two, 2..32.
REQ-004 Parameter ISR_VEC, default 4, interrupt vector, PC_W bits.
REQ-005 Parameter RST_VEC, default 0, reset vector, PC_W bits.
REQ-006 Parameter WRAP, default 1: 1 = circular stack; 0 = saturating stack.
REQ-007 clk  in  1  clock; all state changes on the rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 incr_en  in  1  pc <= pc+1.
REQ-010 skip_en  in  1  pc <= pc+2 (skip instruction); overrides incr_en.
REQ-011 j_en  in  1  jump to composed target.
REQ-012 j_push_en  in  1  jump to composed target and push pc.
REQ-013 pop_en  in  1  return: pc <= top of stack, pop.
REQ-014 isr_en  in  1  pc <= ISR_VEC, push pc.
REQ-015 j_addr  in  JA_W  jump address.
REQ-016 pclath_wr_en / pclath_in  in  1 / PC_W-8  PCLATH write.
REQ-017 pcl_wr_en / pcl_in  in  1 / 8  PCL write (computed jump).
REQ-018 err_clr  in  1  clears sticky ovf/unf.
REQ-019 pc_out  out  PC_W  fetch address (forwarded, REQ-027).
REQ-020 pclath_out  out  PC_W-8  pc[PC_W-1:8].
REQ-021 pcl_out  out  8  pc[7:0].
REQ-022 stk_level  out  clog2(DEPTH)+1  valid entries, 0..DEPTH.
REQ-023 stk_empty / stk_full  out  1 / 1  level==0 / level==DEPTH.
REQ-024 stk_ovf / stk_unf  out  1 / 1  sticky overflow / underflow.

Function
REQ-025 Priority per cycle: isr_en > (j_en|j_push_en) > pop_en > sequential group; lower-priority requests in the same cycle are ignored entirely, including their stack effects.
REQ-026 Sequential group (no higher request): skip_en/incr_en update pc; pclath_wr_en loads pclath; pcl_wr_en loads pc <= {pclath, pcl_in}, overriding incr/skip; pclath written same cycle does not affect that cycle's PCL load.
REQ-027 pc_out = {pclath, pcl_in} while pcl_wr_en is high, else pc (combinational forward).
REQ-028 Jump target = {pclath[PC_W-9:JA_W-8], j_addr}; when JA_W == PC_W the target is j_addr.
REQ-029 pc arithmetic is modulo 2^PC_W; pc = all-ones with incr -> 0, with skip -> 1.
REQ-030 Pushed value is the current registered pc (already incremented past the call); no latency beyond one edge.
REQ-031 Push, level < DEPTH: write entry, level+1.
REQ-032 Push when full, WRAP=1: overwrite oldest entry, level stays DEPTH, stk_ovf set; jump still taken.
REQ-033 Push when full, WRAP=0: value discarded, stack unchanged, stk_ovf set; jump still taken.
REQ-034 Pop, level > 0: pc <= top entry, level-1.
REQ-035 Pop when empty, WRAP=1: pc <= entry at circular pointer-1, pointer decrements, level stays 0, stk_unf set.
REQ-036 Pop when empty, WRAP=0: pc <= pc+1, stack unchanged, stk_unf set.
REQ-037 err_clr clears stk_ovf/stk_unf; a same-cycle new error wins (flag set).

Reset
REQ-038 On rst: pc = RST_VEC, pclath = 0, stack pointer = 0, level = 0, stk_ovf = stk_unf = 0; all other inputs ignored that cycle.
REQ-039 Stack entry contents are not reset; reset mid-call discards all return addresses.

Verification
REQ-040 Reset, then 3 cycles incr_en -> pc_out 0,1,2,3; skip_en at pc 3 -> 5.
REQ-041 pclath_in=0x18, j_push_en j_addr=0x123 at pc 0x010 -> pc 0x1923, level 1; pop_en -> pc 0x010, level 0, empty=1.
REQ-042 9 nested calls, DEPTH=8, WRAP=1 -> ovf=1, level 8; 8 pops return addresses of calls 9..2; 9th pop sets unf.
REQ-043 Same with WRAP=0 -> 9th push discarded; 8 pops return calls 8..1; 9th pop gives pc+1, unf=1; err_clr clears both.
REQ-044 isr_en with pop_en and j_en same cycle at pc 0x055 -> pc 0x004, level +1, later pop -> 0x055.
REQ-045 pcl_wr_en pcl_in=0x40, pclath=0x02, incr_en -> pc_out 0x240 same cycle, pc 0x240 next; rst mid-sequence -> RST_VEC, flags 0.
